// File: rtl/mul4_fitness_scorer_if.sv
`timescale 1ns/1ps
// Batch bus for mul4_fitness_scorer: candidate operand/product bit-planes.
// Handshake: a batch transfers on a rising edge where in_valid && in_ready.
interface mul4_fitness_scorer_if #(
    parameter int LANES = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] a1;
    logic [LANES-1:0] a0;
    logic [LANES-1:0] b1;
    logic [LANES-1:0] b0;
    logic [LANES-1:0] y3;
    logic [LANES-1:0] y2;
    logic [LANES-1:0] y1;
    logic [LANES-1:0] y0;

    modport master (
        output in_valid, a1, a0, b1, b0, y3, y2, y1, y0,
        input  in_ready
    );

    modport slave (
        input  in_valid, a1, a0, b1, b0, y3, y2, y1, y0,
        output in_ready
    );
endinterface

// File: rtl/mul4_fitness_scorer.sv
`timescale 1ns/1ps
// Scores a bit-sliced 2x2 multiplier candidate: counts output bits matching the
// golden product over NUM_BATCHES batches through a 3-edge pipeline.
module mul4_fitness_scorer #(
    parameter int LANES       = 16,
    parameter int NUM_BATCHES = 4,
    parameter int SCORE_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    mul4_fitness_scorer_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic [SCORE_W-1:0]   score,
    output logic                 perfect,
    output logic [1:0]           dbg_state_o
);

    localparam int    MASK_W  = 4 * LANES;
    localparam int    POP_W   = $clog2(MASK_W + 1);
    localparam int    CNT_W   = $clog2(NUM_BATCHES + 1);
    localparam longint MAX_SC = longint'(MASK_W) * longint'(NUM_BATCHES);

    if (MAX_SC >= (64'd1 << SCORE_W)) begin : g_bad_score_w
        $error("SCORE_W too narrow for 4*LANES*NUM_BATCHES");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [SCORE_W-1:0] score_q;
    logic               s1_valid_q, s1_last_q;
    logic [MASK_W-1:0]  s1_mask_q;
    logic               s2_valid_q, s2_last_q;
    logic [POP_W-1:0]   s2_pop_q;

    logic               ready_w;
    logic               clear_w;
    logic               accept_w;
    logic               last_w;
    logic [LANES-1:0]   p3, p2, p1, p0;
    logic [MASK_W-1:0]  mask_d;
    logic [POP_W-1:0]   pop_d;

    // Golden 2x2 product per lane, evaluated bitwise across all lanes at once.
    always_comb begin
        p0     = bus.a0 & bus.b0;
        p1     = (bus.a1 & bus.b0) ^ (bus.a0 & bus.b1);
        p2     = bus.a1 & bus.b1 & ~(bus.a0 & bus.b0);
        p3     = bus.a1 & bus.a0 & bus.b1 & bus.b0;
        mask_d = {~(bus.y3 ^ p3), ~(bus.y2 ^ p2), ~(bus.y1 ^ p1), ~(bus.y0 ^ p0)};
    end

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < MASK_W; i++) begin
            pop_d = pop_d + POP_W'(s1_mask_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        clear_w = 1'b0;
        ready_w = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clear_w = 1'b1;
                end
            end
            RUN: begin
                busy    = 1'b1;
                ready_w = (cnt_q < CNT_W'(NUM_BATCHES));
                // Completion is tied to the final batch reaching the accumulator.
                if (s2_valid_q && s2_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = RUN;
                    clear_w = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept_w     = bus.in_valid & ready_w;
    assign last_w       = (cnt_q == CNT_W'(NUM_BATCHES - 1));
    assign bus.in_ready = ready_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            score_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mask_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_pop_q   <= '0;
        end else begin
            s1_valid_q <= accept_w;
            s1_last_q  <= accept_w & last_w;
            if (accept_w) begin
                s1_mask_q <= mask_d;
            end
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                s2_pop_q <= pop_d;
            end
            // Pipeline is always empty when a clear occurs (IDLE or DONE only).
            if (clear_w) begin
                cnt_q   <= '0;
                score_q <= '0;
            end else begin
                if (accept_w) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (s2_valid_q) begin
                    score_q <= score_q + SCORE_W'(s2_pop_q);
                end
            end
        end
    end

    assign score       = score_q;
    assign perfect     = done && (score_q == SCORE_W'(MAX_SC));
    assign dbg_state_o = state_q;

endmodule

// File: doc/mul4_fitness_scorer.md
Name: mul4_fitness_scorer

Overview:
- Downstream scoring stage for the bit-sliced 2x2-bit multiplier candidates.
- A candidate takes 16-lane vectors a1,a0,b1,b0 and produces y3..y0. Lane i holds one test case: A={a1[i],a0[i]}, B={b1[i],b0[i]}, product P={y3[i],y2[i],y1[i],y0[i]}.
- This block takes candidate input/output batches over a valid/ready handshake and computes the golden product per lane.
- It counts matching output bits and accumulates them over NUM_BATCHES batches into a fitness score for the tournament selector.

Parameters:
- LANES, 16, bits per vector (test cases per batch).
- NUM_BATCHES, 4, batches per evaluation.
- SCORE_W, 16, accumulator width; must hold 4*LANES*NUM_BATCHES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new evaluation (pulse).
- in_valid  in  1  batch present on a*/b*/y*.
- in_ready  out  1  block accepts batch this cycle.
- a1, a0, b1, b0  in  LANES each  operand bit-planes.
- y3, y2, y1, y0  in  LANES each  candidate product bit-planes.
- busy  out  1  evaluation in progress.
- done  out  1  score final (level, held in DONE).
- score  out  SCORE_W  accumulated matching-bit count.
- perfect  out  1  score == 4*LANES*NUM_BATCHES, valid while done.

Behaviour:
- Reset (async, any state, including mid-evaluation):
  - state=IDLE; in_ready=0, busy=0, done=0, perfect=0, score=0.
  - Batch counter and pipeline valid bits cleared; in-flight batches discarded.
- Golden product per lane, bitwise:
  - p0 = a0&b0
  - p1 = (a1&b0)^(a0&b1)
  - p2 = a1&b1&~(a0&b0)
  - p3 = a1&a0&b1&b0
- Match mask m = ~(y3^p3), ~(y2^p2), ~(y1^p1), ~(y0^p0): 4*LANES bits.
- States:
  - IDLE: in_ready=0. start -> RUN; clear score and batch count.
  - RUN: busy=1. in_ready=1 while accepted count < NUM_BATCHES.
    - A batch is accepted on a rising edge with in_valid&in_ready; batch count increments.
    - Once NUM_BATCHES batches are accepted, in_ready drops to 0 the next cycle. Extra in_valid is ignored, not stalled.
    - After the last accepted batch has accumulated -> DONE.
  - DONE: done=1, busy=0. score and perfect are held stable. start -> RUN (clear as above, done=0 the next cycle).
- start in RUN is ignored; the evaluation is never restarted mid-run.
- Pipeline, batch accepted at edge E:
  - Edge E: match mask registered (stage 1).
  - Edge E+1: popcount of mask (0..4*LANES) registered (stage 2).
  - Edge E+2: popcount added to score.
- For the final batch, the edge E+2 also sets state=DONE. done and the final score are visible together in the cycle after E+2.
- Back-to-back acceptance, one batch per cycle, is supported with no bubbles. Gaps in in_valid only delay completion.
- score is visible during RUN as a running partial sum. It is only meaningful when done=1.
- Accumulator is unsigned and never wraps when SCORE_W is legal. Elaboration must fail if 4*LANES*NUM_BATCHES >= 2**SCORE_W.
- perfect is computed combinationally from score and masked by done.

Test Plan:
- Reset, start, then 4 batches with all inputs 0 and all y 0, back-to-back -> score=256, perfect=1. done rises the cycle after the 4th acceptance edge +2.
- All a/b = 16'hFFFF (3*3=9), y3=FFFF, y2=0, y1=0, y0=FFFF, x4 -> score=256. Same with y3=0 -> score=192, perfect=0.
- a/b all 0, y0=16'h0020 (lane 5 wrong) in batch 2 only, others correct -> score=255, perfect=0.
- in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 acceptances, score=256. A 5th in_valid after 4 acceptances sees in_ready=0 and does not change score.
- Assert rst after 2 batches accepted -> all outputs 0 immediately (async). A new start then 4 correct batches -> score=256, no residue from the aborted run.
- start pulsed during RUN -> ignored, final score unchanged. start in DONE -> done=0 next cycle, score=0, a new evaluation proceeds.
